key_debounce: RTL

Input-side companion to the LED blink counters: it conditions a raw, bouncing, active-low push-button into clean, clock-synchronous level and event signals. The raw pin is synchronized, filtered by a counter-based stability check, and converted to single-cycle press/release pulses. An optional long-press detector can be compiled in. The block sits directly behind a board key pin and feeds control logic such as mode or LED select.

---
 rtl/key_debounce.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Conditions a raw, bouncing, active-low push-button into clean, clock-
// synchronous level and event signals:
//   - a two-flop synchronizer brings the asynchronous pin into the clk domain,
//   - a four-state FSM with a saturating counter accepts a new level only after
//     it has been held for DEBOUNCE_CYCLES cycles,
//   - registered one-cycle press / release pulses mark each accepted change,
//   - an optional long-press detector fires once a press has been held for
//     LONG_CYCLES cycles.
//
// Configuration macro:
//   KEY_LONG_PRESS_EN  defined     -> hold counter built, long_press active
//                      not defined -> long_press tied to 0, LONG_CYCLES ignored
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new synchronized level must hold (>= 2)
//   LONG_CYCLES      cycles of accepted press before long_press fires (>= 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   key_n        in   raw button pin, 0 = pressed, asynchronous to clk
//   key_level    out  debounced state, 1 = pressed
//   key_press    out  one-cycle pulse on an accepted press
//   key_release  out  one-cycle pulse on an accepted release
//   long_press   out  one-cycle pulse when a press has been held LONG_CYCLES
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE,          // stable released
    PRESS_WAIT,    // candidate press being filtered
    PRESSED,       // stable pressed
    RELEASE_WAIT   // candidate release being filtered
  } state_t;

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Illegal parameter values leave an empty, visibly named scope in the
  // elaborated hierarchy; it also keeps LONG_CYCLES referenced when the
  // long-press detector is not compiled in.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_out_of_range
  end

  // ---------------------------------------------------------------------------
  // Synchronizer. Both stages reset to 1 so a reset looks like "released".
  // ---------------------------------------------------------------------------
  logic key_meta;
  logic key_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the two
  // synchronizer stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and debounce counter.
  // The counter stops at CNT_LAST: acceptance happens on that terminal value,
  // so it never wraps.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!key_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;              // bounce rejected
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (key_s) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;           // bounce rejected
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode. Values are derived from the transition being taken and
  // registered below, so the outputs line up with the state they describe.
  // ---------------------------------------------------------------------------
  logic level_d;
  logic press_d;
  logic release_d;

  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = (state_q == PRESS_WAIT)   && (state_d == PRESSED);
    release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Long-press detector
  // ---------------------------------------------------------------------------
`ifdef KEY_LONG_PRESS_EN
  localparam int            LW        = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] hold_q;
  logic          fired_q;

  // hold_q counts completed cycles in PRESSED; the cycle key_press is high is
  // the first. Once it reaches HOLD_LAST the pulse fires and fired_q freezes
  // the counter until the FSM leaves PRESSED, which also restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      fired_q    <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (state_q != PRESSED) begin
        hold_q  <= '0;
        fired_q <= 1'b0;
      end else if (!fired_q) begin
        if (hold_q == HOLD_LAST) begin
          fired_q    <= 1'b1;
          long_press <= 1'b1;
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule
